adc_pipe_encoder_gen: RTL

Parametrised digital back-end for the pipelined 1.5-bit/stage ADC. It takes one-hot comparator codes from `NUM_STAGES` 1.5-bit stages plus a `LAST_BITS`-bit final flash stage and realigns them in time, because each stage resolves one cycle after the previous one. It then applies overlap-add digital error correction and emits one `NUM_STAGES+LAST_BITS`-bit code per sample at full throughput. Compared with the fixed 3-bit encoder, it adds:
- sample-valid tracking,
- invalid-code detection and substitution,
- a saturating error counter.

---
 rtl/adc_pipe_pkg.sv | 25 ++
 rtl/adc_pipe_ohdec.sv | 33 +++
 rtl/adc_pipe_encoder_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/adc_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pipe_pkg
// Description : Shared constants and helpers for the pipelined 1.5-bit/stage
//               ADC digital back-end (one-hot codes, mid-code substitute,
//               output width function).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pipe_pkg;

    // One-hot comparator codes produced by a 1.5-bit stage
    localparam logic [2:0] OH_CODE0 = 3'b001;
    localparam logic [2:0] OH_CODE1 = 3'b010;
    localparam logic [2:0] OH_CODE2 = 3'b100;

    // Value used in place of a stage decision that is not a legal one-hot code
    localparam logic [1:0] MID_CODE = 2'd1;

    // Width of the corrected output word
    function automatic int out_w(input int n, input int l);
        return n + l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_pipe_ohdec.sv
`default_nettype none
// ============================================================================
// Module      : adc_pipe_ohdec
// Description : 3-bit one-hot to 2-bit binary decoder for one 1.5-bit stage.
//               Illegal codes (none or several bits set) decode to the
//               mid code and raise o_invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pipe_ohdec
    import adc_pipe_pkg::*;
(
    input  logic [2:0] i_onehot,
    output logic [1:0] o_code,
    output logic       o_invalid
);

    // Map each legal one-hot pattern to its index; anything else is substituted
    always_comb begin
        o_code    = MID_CODE;
        o_invalid = 1'b0;
        case (i_onehot)
            OH_CODE0: o_code = 2'd0;
            OH_CODE1: o_code = 2'd1;
            OH_CODE2: o_code = 2'd2;
            default: begin
                o_code    = MID_CODE;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/adc_pipe_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_pipe_encoder_gen
// Description : Parametrised back-end for a pipelined 1.5-bit/stage ADC.
//               Decodes each stage, realigns the stage decisions in time,
//               applies overlap-add correction and tracks sample validity
//               and invalid-code errors with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pipe_encoder_gen
    import adc_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int LAST_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                                    clock_i,
    input  logic                                    reset_i,
    input  logic                                    valid_i,
    input  logic [3*NUM_STAGES-1:0]                 d_stage_i,
    input  logic [LAST_BITS-1:0]                    d_last_stage_i,
    input  logic                                    clr_i,
    output logic [out_w(NUM_STAGES, LAST_BITS)-1:0] d_o,
    output logic                                    valid_o,
    output logic                                    err_o,
    output logic [ERR_CNT_W-1:0]                    err_cnt_o
);

    localparam int DW = out_w(NUM_STAGES, LAST_BITS);

    // Aligned stage decisions and error flags, all belonging to the same sample
    logic [2*NUM_STAGES-1:0] w_tap_code;
    logic [NUM_STAGES-1:0]   w_tap_err;

    logic [NUM_STAGES-1:0]   r_tag;
    logic [NUM_STAGES-1:0]   w_tag_nxt;
    logic [DW-1:0]           w_sum;
    logic                    w_any_err;
    logic [DW-1:0]           r_d;
    logic [DW-1:0]           w_d_nxt;
    logic                    r_valid;
    logic                    r_err;
    logic                    w_err_nxt;
    logic [ERR_CNT_W-1:0]    r_err_cnt;
    logic [ERR_CNT_W-1:0]    w_err_cnt_nxt;

    // Stage k resolves k-1 cycles after launch, so it needs N-k+1 delay
    // registers to line up with the final flash stage at launch+N.
    genvar gs;
    generate
        for (gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
            localparam int DEPTH = NUM_STAGES - gs;

            logic [1:0]         w_code;
            logic               w_inv;
            logic [3*DEPTH-1:0] r_dly;
            logic [3*DEPTH-1:0] w_dly_nxt;

            adc_pipe_ohdec u_dec (
                .i_onehot  (d_stage_i[3*gs +: 3]),
                .o_code    (w_code),
                .o_invalid (w_inv)
            );

            // Shift the {error, code} entry one position deeper each cycle
            always_comb begin
                w_dly_nxt = (3*DEPTH)'({r_dly, w_inv, w_code});
            end

            // Delay-line register
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= w_dly_nxt;
                end
            end

            assign w_tap_code[2*gs +: 2] = r_dly[3*DEPTH-2 -: 2];
            assign w_tap_err[gs]         = r_dly[3*DEPTH-1];
        end
    endgenerate

    // Valid tag travels alongside stage 1 data through an N-deep shift
    always_comb begin
        w_tag_nxt = NUM_STAGES'({r_tag, valid_i});
    end

    // Valid tag register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_tag <= '0;
        end else begin
            r_tag <= w_tag_nxt;
        end
    end

    // Overlap-add: stage k carries weight 2^(N-k+L-1); the sum cannot exceed
    // 2^(N+L)-1, so no saturation is needed at full output width.
    always_comb begin
        w_sum     = DW'(d_last_stage_i);
        w_any_err = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            w_sum     = w_sum + (DW'(w_tap_code[2*s +: 2]) << (NUM_STAGES - s - 2 + LAST_BITS));
            w_any_err = w_any_err | w_tap_err[s];
        end
    end

    // Capture a completed sample; hold the previous result otherwise
    always_comb begin
        w_d_nxt   = r_d;
        w_err_nxt = r_err;
        if (r_tag[NUM_STAGES-1]) begin
            w_d_nxt   = w_sum;
            w_err_nxt = w_any_err;
        end
    end

    // Counter counts presented erroneous samples; clear wins over increment
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (clr_i) begin
            w_err_cnt_nxt = '0;
        end else if (r_valid && r_err && !(&r_err_cnt)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    // Output and counter registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_d       <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_d       <= w_d_nxt;
            r_valid   <= r_tag[NUM_STAGES-1];
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign d_o       = r_d;
    assign valid_o   = r_valid;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire
